// File: rtl/seq_pkg.sv
// Shared types and constants for the detector-FSM sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } seq_state_t;

  localparam logic [1:0] Y_HIT     = 2'b01;
  localparam logic [1:0] S_ILLEGAL = 2'b01;
  localparam logic [1:0] S_RESET   = 2'b00;

endpackage

// File: rtl/seq_step_ctr.sv
// Step counter for the sequencer; flags the final step of the current run.
module seq_step_ctr #(
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [LW-1:0] len,
  output logic [LW-1:0] step,
  output logic          last
);

  logic [LW-1:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (clr) begin
      step_d = '0;
    end else if (en) begin
      step_d = step_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;
  assign last = (step_q == len - LW'(1));

endmodule

// File: rtl/fsm_sequencer.sv
// Shifts a parallel pattern into the Mealy detector FSM and captures its outputs.
// Optional SEQ_TRACE_EN adds a per-step capture of the FSM state on port trace.
module fsm_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned LW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   pat,
  input  logic [LW-1:0]  len,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*N-1:0] result,
  output logic [LW-1:0]  hits,
  output logic           fsm_x,
  output logic           fsm_rst,
  input  logic [1:0]     fsm_y,
  input  logic [1:0]     fsm_s
`ifdef SEQ_TRACE_EN
  ,
  output logic [2*N-1:0] trace
`endif
);

  seq_state_t     state_q, state_d;
  logic [N-1:0]   pat_q, pat_d;
  logic [LW-1:0]  len_q, len_d;
  logic [2*N-1:0] result_q, result_d;
  logic [LW-1:0]  hits_q, hits_d;
  logic           err_q, err_d;
  logic           len_bad;
  logic           ctr_clr, ctr_en, last;
  logic [LW-1:0]  step;

  seq_step_ctr #(
    .LW (LW)
  ) u_step_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .en   (ctr_en),
    .len  (len_q),
    .step (step),
    .last (last)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    result_d = result_q;
    hits_d   = hits_q;
    err_d    = err_q;
    busy     = 1'b0;
    done     = 1'b0;
    fsm_rst  = 1'b1;
    fsm_x    = 1'b0;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    len_bad  = (len == '0) || (len > LW'(N));
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d    = pat;
          len_d    = len;
          result_d = '0;
          hits_d   = '0;
          err_d    = len_bad;
          state_d  = len_bad ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        ctr_clr = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        fsm_rst  = 1'b0;
        ctr_en   = 1'b1;
        fsm_x    = |(pat_q & (N'(1) << step));
        // result is zeroed at start and each slot written once, so OR-in is enough
        result_d = result_q | ({{(2*N-2){1'b0}}, fsm_y} << {step, 1'b0});
        if (fsm_y == Y_HIT) hits_d = hits_q + LW'(1);
        if (fsm_s == S_ILLEGAL) err_d = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      result_q <= '0;
      hits_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      result_q <= result_d;
      hits_q   <= hits_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign hits   = hits_q;
  assign err    = err_q;

`ifdef SEQ_TRACE_EN
  logic [2*N-1:0] trace_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_q <= '0;
    end else if (state_q == IDLE && start) begin
      trace_q <= '0;
    end else if (state_q == RUN) begin
      trace_q <= trace_q | ({{(2*N-2){1'b0}}, fsm_s} << {step, 1'b0});
    end
  end

  assign trace = trace_q;
`endif

endmodule
